// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Conditions a raw asynchronous level (switch contact or off-chip signal).
// The level first goes through a SYNC_STAGES-deep synchroniser. A four-state
// FSM then accepts a level change only after the synchronised level s has
// disagreed with q for DEBOUNCE_CYCLES consecutive enabled samples.
//
// Parameters
//   SYNC_STAGES      synchroniser depth, 2..4
//   DEBOUNCE_CYCLES  consecutive samples needed to accept a change,
//                    1..(2^CNT_W - 1)
//   CNT_W            debounce counter width in bits
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset of all state
//   d_in   in   raw asynchronous level
//   en     in   synchronous enable for the debounce FSM (not the synchroniser)
//   q      out  debounced, synchronised level (registered)
//   qbar   out  complement of q
//   rise   out  one-cycle pulse on q 0->1 (registered)
//   fall   out  one-cycle pulse on q 1->0 (registered)
//   busy   out  high while a candidate level change is being counted
// -----------------------------------------------------------------------------
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  input  logic en,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Largest count the counter can hold; longint keeps wide CNT_W from overflowing.
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Parameter legality is checked at elaboration so a bad configuration
  // never reaches synthesis.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("debounce_sync: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("debounce_sync: CNT_W=%0d must be at least 1", CNT_W);
  end
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > CNT_MAX) begin : g_bad_debounce
    $error("debounce_sync: DEBOUNCE_CYCLES=%0d outside 1..%0d", DEBOUNCE_CYCLES, CNT_MAX);
  end

  // Count value on which the last confirming sample is taken.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               DIRECT   = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  // Synchroniser: shifts every cycle regardless of en; s is the only
  // consumer-visible copy of d_in.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Debounce FSM. q, busy, rise and fall are registered alongside the state
  // so they change on the same edge as the state that defines them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STABLE_LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // Pulses last one cycle unless re-asserted below.
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        STABLE_LO: begin
          cnt <= '0;
          if (en && s) begin
            if (DIRECT) begin
              state <= STABLE_HI;
              q     <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= CHK_HI;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end

        CHK_HI: begin
          if (!en || !s) begin
            // Glitch or disable: abandon the candidate, q unchanged.
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            cnt   <= '0;
            q     <= 1'b1;
            rise  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        STABLE_HI: begin
          cnt <= '0;
          if (en && !s) begin
            if (DIRECT) begin
              state <= STABLE_LO;
              q     <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= CHK_LO;
              cnt   <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end

        CHK_LO: begin
          if (!en || s) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            q     <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          q     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so it tracks q through reset as well.
  assign qbar = ~q;

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//
// Bench for debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4. Inputs are
// driven 1 ns after each rising edge and outputs are sampled 1 ns after it.
// The reference model describes the behaviour as "s is d_in delayed by
// SYNC_STAGES edges; q flips once s has disagreed with q on DEBOUNCE_CYCLES
// consecutive enabled edges".
// -----------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic reset;
  logic d_in;
  logic en;
  logic q, qbar, rise, fall, busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic m_sync [SYNC];
  logic m_q, m_rise, m_fall, m_busy;
  int   run;

  debounce_sync #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .d_in (d_in),
    .en   (en),
    .q    (q),
    .qbar (qbar),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] dut_vec();
    return {q, qbar, rise, fall, busy};
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_q, ~m_q, m_rise, m_fall, m_busy};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
    run = 0;
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic s_old;
    s_old = m_sync[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = d_in;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (en && (s_old != m_q)) begin
      run++;
      if (run == DEB) begin
        m_q = s_old;
        if (s_old) m_rise = 1'b1;
        else       m_fall = 1'b1;
        run = 0;
      end
    end else begin
      run = 0;
    end
    m_busy = (run != 0);
  endtask

  // Advance to 1 ns after the next rising edge, stepping the model.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
  endtask

  // Called 1 ns after an edge; releases reset at the following falling edge.
  task automatic release_reset();
    #4;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; d_in = 1'b0; en = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if (dut_vec() !== 5'b01000) begin
      n_err++;
      $display("FAIL reset_pre_clk got=%b exp=01000 {q,qbar,rise,fall,busy}", dut_vec());
    end
    tick();
    tick();
    n_vec++;
    if (dut_vec() !== 5'b01000) begin
      n_err++;
      $display("FAIL reset_held got=%b exp=01000", dut_vec());
    end
    release_reset();
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec() || q !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle k=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clean_step();
    logic [4:0] want;
    d_in = 1'b1; en = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      want = {k >= 5, k < 5, k == 5, 1'b0, (k >= 2 && k <= 4)};
      n_vec++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL clean_step edge=%0d got=%b exp=%b model=%b", k, dut_vec(), want, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    d_in = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_vec++;
    if ({q, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL async_reset_setup got q,busy=%b exp=11", {q, busy});
    end
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({q, qbar, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL async_reset_immediate got q,qbar,busy=%b exp=010", {q, qbar, busy});
    end
    tick();
    release_reset();
  endtask

  task automatic test_glitch();
    bit saw_busy = 1'b0;
    bit saw_bad  = 1'b0;
    d_in = 1'b1; en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) d_in = 1'b0;
      tick();
      if (busy) saw_busy = 1'b1;
      if (q || rise) saw_bad = 1'b1;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL glitch edge=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (saw_busy !== 1'b1 || saw_bad !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_summary got busy_seen=%b q_or_rise_seen=%b busy_end=%b exp 1 0 0",
               saw_busy, saw_bad, busy);
    end
  endtask

  task automatic test_en_drop();
    d_in = 1'b1; en = 1'b1;
    for (int k = 0; k <= 3; k++) tick();
    n_vec++;
    if ({q, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL en_drop_counting got q,busy=%b exp=01", {q, busy});
    end
    en = 1'b0;
    tick();
    n_vec++;
    if (dut_vec() !== 5'b01000 || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL en_drop_abandon got=%b exp=01000", dut_vec());
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++;
      if (q !== (k == 4) || rise !== (k == 4) || dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL en_drop_recount sample=%0d got=%b model=%b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_fall();
    logic [4:0] want;
    d_in = 1'b0; en = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      want = {k < 5, k >= 5, 1'b0, k == 5, (k >= 2 && k <= 4)};
      n_vec++;
      if (dut_vec() !== want || dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL fall_step edge=%0d got=%b exp=%b", k, dut_vec(), want);
      end
    end
  endtask

  task automatic test_reset_midcount();
    d_in = 1'b1; en = 1'b1;
    for (int k = 0; k <= 4; k++) tick();
    n_vec++;
    if ({q, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL midcount_setup got q,busy=%b exp=01", {q, busy});
    end
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({q, qbar, rise, busy} !== 4'b0100) begin
      n_err++;
      $display("FAIL midcount_reset got q,qbar,rise,busy=%b exp=0100", {q, qbar, rise, busy});
    end
    tick();
    release_reset();
    for (int k = 0; k <= 6; k++) begin
      tick();
      n_vec++;
      if (q !== (k >= 5) || rise !== (k == 5) || dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL midcount_relatency edge=%0d got=%b model=%b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        d_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 7);
      end
      hold--;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (dut_vec() !== 5'b01000) begin
          n_err++;
          $display("FAIL random_reset cycle=%0d got=%b exp=01000", c, dut_vec());
        end
        tick();
        release_reset();
      end
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec() || (rise && fall)) begin
        n_err++;
        $display("FAIL random cycle=%0d d_in=%b en=%b got=%b exp=%b", c, d_in, en, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_async_reset();
    test_glitch();
    test_en_drop();
    test_fall();
    test_reset_midcount();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
